wav_synth_mc: RTL
=================

// Module: wav_synth_mc
// PURPOSE
//  Multi-channel wavetable sound generator, generalising the single-channel FDS wave unit to NUM_CH channels.
//  Each channel has its own wave RAM, frequency accumulator and volume. One shared multiplier is time-multiplexed
//  across the channels on each sample tick, and the products are summed into one mixed output. Sits under a mapper's
//  register decode; the mixed output feeds the cart audio DAC path.
// PARAMETERS
//  NUM_CH  4   channels, 1..4
//  WAV_AW  5   log2 samples per channel wave (32)
//  WAV_DW  6   sample width, unsigned
//  FREQ_W  12  channel frequency register width
//  ACC_W   18  phase accumulator width; top WAV_AW bits = wave index, low ACC_W-WAV_AW bits = fraction
//  OUT_W   WAV_DW+6+2  mixed output width (6 = clamped-volume bits, 2 = log2 of max NUM_CH)
// PORTS
//  clk       in   1      system clock
//  map_rst   in   1      sync active-high reset
//  tick      in   1      sample-rate strobe, 1-cycle pulse
//  reg_we    in   1      register write strobe
//  reg_addr  in   9      register address
//  reg_wdat  in   8      write data
//  reg_rdat  out  8      read data, combinational from reg_addr
//  snd_out   out  OUT_W  mixed sample
//  snd_vld   out  1      1-cycle pulse when snd_out updates
//  busy      out  1      sequencer active
// BEHAVIOUR
//  Register map
//   0x000-0x0FF  wave RAM, addr={ch,idx}; write-only to halted channels; reads always return {2'b0,sample}
//   0x100+8*ch+0 freq[7:0]
//   0x100+8*ch+1 {halt,3'b0,freq[11:8]}
//   0x100+8*ch+2 vol[5:0]
//   0x100+8*ch+3 env ctrl {off,dir,spd[5:0]}
//   0x100+8*ch+4 env period[7:0]
//   0x100+8*ch+5 RO {3'b0,idx}
//   0x1F0        {ovr(RO),5'b0,mvol[1:0]}; any write clears ovr
//   other / ch>=NUM_CH: reads 8'h00, writes ignored
//  Reset values
//   snd_out=0, snd_vld=0, busy=0, all freq=0, halt=1, vol=0, acc=0, mvol=0, ovr=0; wave RAM not reset
//  Sequencer: IDLE -> RUN -> DRAIN -> IDLE
//   IDLE: on tick -> RUN, ch=0, busy=1
//   RUN, per cycle for ch:
//    - read sample at acc[ACC_W-1 -: WAV_AW]
//    - acc <= acc + freq (mod 2^ACC_W; index wraps 31->0)
//    - ch<NUM_CH-1: ch++; else -> DRAIN
//   Multiplier stage (1 cycle behind RUN): prod = sample * min(vol,32); halted channel contributes 0 and acc held at 0
//   Accumulator stage (1 cycle behind multiplier): sum += prod
//   DRAIN: snd_out <= sum >> mvol; snd_vld=1 for 1 cycle; busy=0; sum cleared -> IDLE
//   Latency: tick at cycle T gives snd_vld at T+NUM_CH+2
//  halt write
//   1: acc cleared on the same cycle as the write
//   0: acc starts from 0
//  Boundary rules
//   tick while busy: ignored; ovr=1 (sticky)
//   reg write to freq/vol during RUN: takes effect for channels not yet visited in this pass
//   wave write and sequencer read of the same word in one cycle: sequencer gets old data
//   map_rst mid-pass: everything back to reset state next cycle; no snd_vld
// CONFIGURATION
//  WSM_ENV_EN defined, per channel:
//   - counter reloads from period; decrements once per tick
//   - at 0, if env off=0, vol steps by 1: dir=1 up to 32, dir=0 down to 0
//   - write to ctrl with off=1 loads vol<=spd
//   - period=0 freezes the envelope
//  WSM_ENV_EN undefined:
//   - regs +3/+4 read 0, writes ignored
//   - vol changes only by direct write
// TESTING
//  1 Reset: after map_rst, snd_out=0, busy=0, reads of 0x101=8'h80, 0x1F0=0
//  2 ch0 wave = ramp 0..31, vol=16, freq=0x800, halt=0
//    -> idx advances every 4 ticks; snd_out = 16*idx; snd_vld at T+NUM_CH+2
//  3 Volume clamp: vol=40, sample=63 -> snd_out=2016; with mvol=2 -> 504
//  4 Wave write to running ch0 at 0x003 -> RAM unchanged; after halt=1 the write lands and reads back
//  5 Second tick 2 cycles after first -> ignored, 0x1F0 reads 8'h80; write 0x1F0 clears it
//  6 WSM_ENV_EN: ctrl=0x40|vol 0, period=2 -> vol +1 every 3 ticks, saturates at 32

Source files
------------

// File: rtl/wav_synth_mc.sv
// Multi-channel wavetable generator: per-channel wave RAM, phase accumulator and volume, one shared
// multiplier walked across channels per tick and mixed into snd_out. Optional envelope under WSM_ENV_EN.
module wav_synth_mc #(
  parameter int NUM_CH = 4,
  parameter int WAV_AW = 5,
  parameter int WAV_DW = 6,
  parameter int FREQ_W = 12,
  parameter int ACC_W  = 18,
  parameter int OUT_W  = WAV_DW + 6 + 2
) (
  input  logic             clk,
  input  logic             map_rst,
  input  logic             tick,
  input  logic             reg_we,
  input  logic [8:0]       reg_addr,
  input  logic [7:0]       reg_wdat,
  output logic [7:0]       reg_rdat,
  output logic [OUT_W-1:0] snd_out,
  output logic             snd_vld,
  output logic             busy
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RAM_AW = CH_W + WAV_AW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  logic [WAV_DW-1:0] wav_mem [NUM_CH << WAV_AW];

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              busy_q, busy_d, snd_vld_q, snd_vld_d, ovr_q, ovr_d;
  logic [1:0]        mvol_q, mvol_d;
  logic [OUT_W-1:0]  snd_out_q, snd_out_d, sum_q, sum_d, prod_q, prod_d;
  logic [NUM_CH-1:0] halt_q, halt_d;
  logic [FREQ_W-1:0] freq_q [NUM_CH];
  logic [FREQ_W-1:0] freq_d [NUM_CH];
  logic [5:0]        vol_q [NUM_CH];
  logic [5:0]        vol_d [NUM_CH];
  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
`ifdef WSM_ENV_EN
  logic [7:0]        env_ctrl_q [NUM_CH];
  logic [7:0]        env_ctrl_d [NUM_CH];
  logic [7:0]        env_per_q [NUM_CH];
  logic [7:0]        env_per_d [NUM_CH];
  logic [7:0]        env_cnt_q [NUM_CH];
  logic [7:0]        env_cnt_d [NUM_CH];
`endif

  logic              wav_we;
  logic [WAV_DW-1:0] run_samp;
  logic [5:0]        run_vol;
  logic [4:0]        reg_ch;
  logic [2:0]        reg_off;
  logic [7-WAV_AW:0] wav_ch;

  assign reg_ch  = reg_addr[7:3];
  assign reg_off = reg_addr[2:0];
  assign wav_ch  = reg_addr[7:WAV_AW];
  assign run_samp = wav_mem[{ch_q, acc_q[ch_q][ACC_W-1 -: WAV_AW]}];
  assign run_vol  = (vol_q[ch_q] > 6'd32) ? 6'd32 : vol_q[ch_q];

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    busy_d    = busy_q;
    snd_vld_d = 1'b0;
    snd_out_d = snd_out_q;
    sum_d     = sum_q;
    prod_d    = '0;
    ovr_d     = ovr_q;
    mvol_d    = mvol_q;
    halt_d    = halt_q;
    wav_we    = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      freq_d[c] = freq_q[c];
      vol_d[c]  = vol_q[c];
      acc_d[c]  = acc_q[c];
`ifdef WSM_ENV_EN
      env_ctrl_d[c] = env_ctrl_q[c];
      env_per_d[c]  = env_per_q[c];
      env_cnt_d[c]  = env_cnt_q[c];
      if (tick && env_per_q[c] != 8'd0) begin
        if (env_cnt_q[c] == 8'd0) begin
          env_cnt_d[c] = env_per_q[c];
          if (!env_ctrl_q[c][7]) begin
            if (env_ctrl_q[c][6]) begin
              if (vol_q[c] < 6'd32) vol_d[c] = vol_q[c] + 6'd1;
            end else if (vol_q[c] != 6'd0) begin
              vol_d[c] = vol_q[c] - 6'd1;
            end
          end
        end else begin
          env_cnt_d[c] = env_cnt_q[c] - 8'd1;
        end
      end
`endif
    end

    case (state_q)
      S_IDLE: if (tick) begin
        state_d = S_RUN;
        ch_d    = '0;
        busy_d  = 1'b1;
      end
      S_RUN: begin
        // the previous channel's product lands in the sum while this one is multiplied
        sum_d = sum_q + prod_q;
        if (!halt_q[ch_q]) begin
          prod_d       = OUT_W'(run_samp) * OUT_W'(run_vol);
          acc_d[ch_q]  = acc_q[ch_q] + ACC_W'(freq_q[ch_q]);
        end
        if (int'(ch_q) == NUM_CH - 1) state_d = S_DRAIN;
        else                          ch_d    = ch_q + 1'b1;
      end
      S_DRAIN: begin
        snd_out_d = (sum_q + prod_q) >> mvol_q;
        snd_vld_d = 1'b1;
        busy_d    = 1'b0;
        sum_d     = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (reg_we) begin
      if (!reg_addr[8]) begin
        for (int c = 0; c < NUM_CH; c++)
          if (int'(wav_ch) == c && halt_q[c]) wav_we = 1'b1;
      end else if (reg_addr == 9'h1F0) begin
        mvol_d = reg_wdat[1:0];
        ovr_d  = 1'b0;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (reg_ch == 5'(c)) begin
            case (reg_off)
              3'd0: freq_d[c][7:0] = reg_wdat;
              3'd1: begin
                freq_d[c][FREQ_W-1:8] = reg_wdat[FREQ_W-9:0];
                halt_d[c] = reg_wdat[7];
                if (reg_wdat[7]) acc_d[c] = '0;
              end
              3'd2: vol_d[c] = reg_wdat[5:0];
`ifdef WSM_ENV_EN
              3'd3: begin
                env_ctrl_d[c] = reg_wdat;
                if (reg_wdat[7]) vol_d[c] = reg_wdat[5:0];
              end
              3'd4: begin
                env_per_d[c] = reg_wdat;
                env_cnt_d[c] = reg_wdat;
              end
`endif
              default: ;
            endcase
          end
        end
      end
    end
    if (tick && state_q != S_IDLE) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (map_rst) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      busy_q    <= 1'b0;
      snd_vld_q <= 1'b0;
      snd_out_q <= '0;
      sum_q     <= '0;
      prod_q    <= '0;
      ovr_q     <= 1'b0;
      mvol_q    <= '0;
      halt_q    <= '1;
      for (int c = 0; c < NUM_CH; c++) begin
        freq_q[c] <= '0;
        vol_q[c]  <= '0;
        acc_q[c]  <= '0;
`ifdef WSM_ENV_EN
        env_ctrl_q[c] <= '0;
        env_per_q[c]  <= '0;
        env_cnt_q[c]  <= '0;
`endif
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      busy_q    <= busy_d;
      snd_vld_q <= snd_vld_d;
      snd_out_q <= snd_out_d;
      sum_q     <= sum_d;
      prod_q    <= prod_d;
      ovr_q     <= ovr_d;
      mvol_q    <= mvol_d;
      halt_q    <= halt_d;
      for (int c = 0; c < NUM_CH; c++) begin
        freq_q[c] <= freq_d[c];
        vol_q[c]  <= vol_d[c];
        acc_q[c]  <= acc_d[c];
`ifdef WSM_ENV_EN
        env_ctrl_q[c] <= env_ctrl_d[c];
        env_per_q[c]  <= env_per_d[c];
        env_cnt_q[c]  <= env_cnt_d[c];
`endif
      end
    end
  end

  // wave RAM keeps its contents across reset; the sequencer reads it asynchronously so it sees pre-write data
  always_ff @(posedge clk) begin
    if (wav_we) wav_mem[reg_addr[RAM_AW-1:0]] <= reg_wdat[WAV_DW-1:0];
  end

  always_comb begin
    reg_rdat = 8'h00;
    if (!reg_addr[8]) begin
      if (int'(wav_ch) < NUM_CH) reg_rdat = 8'(wav_mem[reg_addr[RAM_AW-1:0]]);
    end else if (reg_addr == 9'h1F0) begin
      reg_rdat = {ovr_q, 5'b0, mvol_q};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (reg_ch == 5'(c)) begin
          case (reg_off)
            3'd0: reg_rdat = freq_q[c][7:0];
            3'd1: reg_rdat = {halt_q[c], 3'b0, freq_q[c][FREQ_W-1:8]};
            3'd2: reg_rdat = {2'b0, vol_q[c]};
`ifdef WSM_ENV_EN
            3'd3: reg_rdat = env_ctrl_q[c];
            3'd4: reg_rdat = env_per_q[c];
`endif
            3'd5: reg_rdat = 8'(acc_q[c][ACC_W-1 -: WAV_AW]);
            default: ;
          endcase
        end
      end
    end
  end

  assign snd_out = snd_out_q;
  assign snd_vld = snd_vld_q;
  assign busy    = busy_q;
endmodule
